// File: rtl/cpu_mc_if.sv
// Data-memory handshake bus between cpu_mc and the data RAM/IO side.
// The CPU drives the request, address, store data and direction; memory answers with ack and load data.
interface cpu_mc_if #(
   parameter int DW = 8
);
   logic          o_data_req;
   logic          i_data_ack;
   logic [DW-1:0] i_data;
   logic [DW-1:0] o_data_addr;
   logic [DW-1:0] o_data_data;
   logic          o_data_we;

   modport master (
      output o_data_req, o_data_addr, o_data_data, o_data_we,
      input  i_data_ack, i_data
   );

   modport slave (
      input  o_data_req, o_data_addr, o_data_data, o_data_we,
      output i_data_ack, i_data
   );
endinterface

// File: rtl/cpu_mc.sv
// Multi-cycle 16-opcode register CPU with an inline ALU, a combinational fetch port,
// and a req/ack data port that tolerates any number of memory wait states.
module cpu_mc #(
   parameter int DW = 8,
   parameter int RB = 2,
   parameter int IW = 4 + 2 * RB
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          hlt,
   input  logic [IW-1:0] i_inst,
   output logic [DW-1:0] o_inst_addr,
   output logic          o_retire,
   cpu_mc_if.master      dbus
);
   localparam int NREG = 2 ** RB;
   localparam logic [DW-1:0] DW_V = DW'(DW);

   typedef enum logic { RUN, MEM } state_e;
   typedef enum logic [3:0] {
      OP_LD  = 4'h0, OP_ST  = 4'h1, OP_SGT = 4'h2, OP_SEQ = 4'h3,
      OP_JAL = 4'h4, OP_BGZ = 4'h5, OP_BNZ = 4'h6, OP_BEZ = 4'h7,
      OP_ADD = 4'h8, OP_SUB = 4'h9, OP_NAND = 4'hA, OP_OR = 4'hB,
      OP_XOR = 4'hC, OP_SHL = 4'hD, OP_SRL = 4'hE, OP_SRA = 4'hF
   } op_e;

   state_e        state_q, state_d;
   logic [DW-1:0] pc_q, pc_d;
   logic [IW-1:0] r_inst_q, r_inst_d;
   logic          retire_q, retire_d;
   logic [DW-1:0] reg_q [NREG];

   logic [IW-1:0] cur_inst;
   op_e           op;
   logic [RB-1:0] ra_idx, rb_idx;
   logic [DW-1:0] a, b, pc_inc, alu_y, wr_data;
   logic          is_mem, mem_req, taken, writes_ra, wr_en, shamt_big;

   // While waiting in MEM the latched instruction selects the operands, so address/data stay put.
   assign cur_inst = (state_q == MEM) ? r_inst_q : i_inst;
   assign op       = op_e'(cur_inst[IW-1:IW-4]);
   assign ra_idx   = cur_inst[2*RB-1:RB];
   assign rb_idx   = cur_inst[RB-1:0];
   assign a        = reg_q[ra_idx];
   assign b        = reg_q[rb_idx];
   assign pc_inc   = pc_q + DW'(1);

   assign is_mem    = (op == OP_LD) || (op == OP_ST);
   assign writes_ra = op[3] || (op == OP_SGT) || (op == OP_SEQ) || (op == OP_JAL);
   assign shamt_big = (b >= DW_V);
   assign mem_req   = rst && ((state_q == MEM) || (!hlt && is_mem));

   assign dbus.o_data_req  = mem_req;
   assign dbus.o_data_we   = mem_req && (op == OP_ST);
   assign dbus.o_data_addr = b;
   assign dbus.o_data_data = a;
   assign o_inst_addr      = pc_q;
   assign o_retire         = retire_q;

   // NOTE: every signal driven here gets a default before the case, so no path can infer a latch.
   always_comb begin
      alu_y = '0;
      taken = 1'b0;
      case (op)
         OP_SGT:  alu_y = DW'($signed(a) > $signed(b));
         OP_SEQ:  alu_y = DW'(a == b);
         OP_JAL:  begin alu_y = pc_inc; taken = 1'b1; end
         OP_BGZ:  taken = !a[DW-1] && (a != '0);
         OP_BNZ:  taken = (a != '0);
         OP_BEZ:  taken = (a == '0);
         OP_ADD:  alu_y = a + b;
         OP_SUB:  alu_y = a - b;
         OP_NAND: alu_y = ~(a & b);
         OP_OR:   alu_y = a | b;
         OP_XOR:  alu_y = a ^ b;
         OP_SHL:  alu_y = shamt_big ? '0 : (a << b);
         OP_SRL:  alu_y = shamt_big ? '0 : (a >> b);
         OP_SRA:  alu_y = shamt_big ? {DW{a[DW-1]}} : $unsigned($signed(a) >>> b);
         default: alu_y = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      r_inst_d = r_inst_q;
      retire_d = 1'b0;
      wr_en    = 1'b0;
      wr_data  = alu_y;
      case (state_q)
         RUN: if (!hlt) begin
            if (!is_mem) begin
               retire_d = 1'b1;
               pc_d     = taken ? b : pc_inc;
               wr_en    = writes_ra;
            end else if (dbus.i_data_ack) begin
               retire_d = 1'b1;
               pc_d     = pc_inc;
               wr_en    = (op == OP_LD);
               wr_data  = dbus.i_data;
            end else begin
               r_inst_d = i_inst;
               state_d  = MEM;
            end
         end
         MEM: if (dbus.i_data_ack) begin
            retire_d = 1'b1;
            pc_d     = pc_inc;
            wr_en    = (op == OP_LD);
            wr_data  = dbus.i_data;
            state_d  = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RUN;
         pc_q     <= '0;
         r_inst_q <= '0;
         retire_q <= 1'b0;
         // NOTE: the register file is small and architecturally defined as zero after reset, so it is reset.
         for (int i = 0; i < NREG; i++) reg_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         r_inst_q <= r_inst_d;
         retire_q <= retire_d;
         if (wr_en) reg_q[ra_idx] <= wr_data;
      end
   end
endmodule
